// File: rtl/mem_wb_elastic_stage.sv
// mem_wb_elastic_stage
//   MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid
//   buffer (main slot M drives the outputs, skid slot S catches the one
//   extra entry accepted while WB stalls). Adds synchronous flush and a
//   qualified register-file write enable.
//   Optional feature macro: MEM_WB_PERF_EN adds saturating stall, bubble
//   and flush performance counters.
//
//   Handshake: an entry moves on a rising edge when valid and ready are both
//   high on that interface. in_ready depends only on the stage state and rst,
//   never combinationally on out_ready. out_valid is held with a stable
//   payload until out_ready is seen high.
module mem_wb_elastic_stage #(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5,
  parameter int CNT_W            = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_LEN-1:0]         rd_data,
  input  logic [CONTROL_LINE-1:0]     control_in,
  input  logic [DATA_LEN-1:0]         addr,
  input  logic [INSTRUCTION_PART-1:0] instruction_part,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_LEN-1:0]         rd_data_out,
  output logic [CONTROL_LINE-1:0]     control_out,
  output logic [DATA_LEN-1:0]         addr_out,
  output logic [INSTRUCTION_PART-1:0] instruction_part_out,
  output logic                        wb_we,
  output logic [1:0]                  state_dbg
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            bubble_cnt,
  output logic [CNT_W-1:0]            flush_cnt
`endif
);

  localparam int PW = 2 * DATA_LEN + CONTROL_LINE + INSTRUCTION_PART;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] m_pl;
  logic [PW-1:0] s_pl;
  logic          accept;
  logic          emit;

  // Counter width is only consumed by the optional counters; reject nonsense.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign in_pl = {rd_data, control_in, addr, instruction_part};
  assign {rd_data_out, control_out, addr_out, instruction_part_out} = m_pl;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_TWO) & ~rst;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign wb_we     = emit & control_out[0] & (instruction_part_out != '0);
  assign state_dbg = state;

  // Occupancy FSM and slot payloads; flush clears occupancy but keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      m_pl  <= '0;
      s_pl  <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_pl  <= in_pl;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            m_pl <= in_pl;
          end else if (accept) begin
            s_pl  <= in_pl;
            state <= ST_TWO;
          end else if (emit) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            m_pl  <= s_pl;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef MEM_WB_PERF_EN
  // Saturating event counters, incremented on the edge closing the event cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flush && (state != ST_EMPTY) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// tb_mem_wb_elastic_stage
//   Drives the MEM/WB elastic stage with directed and random traffic and
//   compares every cycle against a FIFO-of-payloads reference model.
module tb_mem_wb_elastic_stage;

  localparam int DL = 64;
  localparam int CL = 2;
  localparam int IP = 5;
  localparam int CW = 32;
  localparam int PW = 2 * DL + CL + IP;

  typedef struct packed {
    logic [DL-1:0] d;
    logic [CL-1:0] c;
    logic [DL-1:0] a;
    logic [IP-1:0] r;
  } pl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DL-1:0] rd_data = '0;
  logic [CL-1:0] control_in = '0;
  logic [DL-1:0] addr = '0;
  logic [IP-1:0] instruction_part = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL-1:0] rd_data_out;
  logic [CL-1:0] control_out;
  logic [DL-1:0] addr_out;
  logic [IP-1:0] instruction_part_out;
  logic          wb_we;
  logic [1:0]    state_dbg;
`ifdef MEM_WB_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  mem_wb_elastic_stage #(
    .DATA_LEN(DL), .CONTROL_LINE(CL), .INSTRUCTION_PART(IP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_data(rd_data), .control_in(control_in), .addr(addr),
    .instruction_part(instruction_part),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_data_out(rd_data_out), .control_out(control_out),
    .addr_out(addr_out), .instruction_part_out(instruction_part_out),
    .wb_we(wb_we), .state_dbg(state_dbg)
`ifdef MEM_WB_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int stall_t = 0;
  int bubble_t = 0;
  int flush_t = 0;
  int emit_seen = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model.
  task automatic cycle(input logic iv, input logic orr, input logic fl, input pl_t p);
    pl_t head;
    logic exp_we;
    @(negedge clk);
    in_valid = iv; out_ready = orr; flush = fl;
    rd_data = p.d; control_in = p.c; addr = p.a; instruction_part = p.r;
    #1;
`ifdef MEM_WB_PERF_EN
    check("stall_cnt", PW'(stall_cnt), PW'(stall_t));
    check("bubble_cnt", PW'(bubble_cnt), PW'(bubble_t));
    check("flush_cnt", PW'(flush_cnt), PW'(flush_t));
`endif
    check("out_valid", PW'(out_valid), PW'(exp_q.size() != 0));
    check("in_ready", PW'(in_ready), PW'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      head = pl_t'(exp_q[0]);
      check("payload", {rd_data_out, control_out, addr_out, instruction_part_out}, exp_q[0]);
      exp_we = orr && head.c[0] && (head.r != 0);
    end else begin
      exp_we = 1'b0;
    end
    check("wb_we", PW'(wb_we), PW'(exp_we));
    if (out_valid && out_ready) emit_seen++;
    // tallies for counters, from the model's occupancy
    if (exp_q.size() == 0) bubble_t++;
    else if (!orr) stall_t++;
    if (fl && exp_q.size() != 0) flush_t++;
    // model update for the coming edge
    if (fl) begin
      exp_q.delete();
    end else begin
      logic can_take;
      can_take = (exp_q.size() < 2);
      if (orr && exp_q.size() != 0) void'(exp_q.pop_front());
      if (iv && can_take) exp_q.push_back(PW'(p));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_in_ready", PW'(in_ready), '0);
      check("rst_payload", {rd_data_out, control_out, addr_out, instruction_part_out}, '0);
      check("rst_wb_we", PW'(wb_we), '0);
      @(negedge clk);
    end
    rst = 1'b0;
    exp_q.delete();
    stall_t = 0; bubble_t = 0; flush_t = 0;
  endtask

  function automatic pl_t rand_pl();
    pl_t p;
    p.d = {$urandom, $urandom};
    p.c = CL'($urandom_range(0, 3));
    p.a = {$urandom, $urandom};
    p.r = IP'($urandom_range(0, 31));
    return p;
  endfunction

  function automatic pl_t mk_pl(input logic [DL-1:0] d, input logic [CL-1:0] c, input logic [IP-1:0] r);
    pl_t p;
    p.d = d; p.c = c; p.a = d + 64'h1000; p.r = r;
    return p;
  endfunction

  initial begin
    pl_t p;
    apply_reset();

    // streaming: 10 payloads back to back, then drain
    emit_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, rand_pl());
    cycle(1'b0, 1'b1, 1'b0, rand_pl());
    check("stream_emits", PW'(emit_seen), PW'(10));
    cycle(1'b0, 1'b1, 1'b0, rand_pl());

    // back-pressure: fill both slots, hold, then drain
    cycle(1'b1, 1'b0, 1'b0, mk_pl(64'hA, 2'b01, 5'd3));
    cycle(1'b1, 1'b0, 1'b0, mk_pl(64'hB, 2'b01, 5'd4));
    cycle(1'b1, 1'b0, 1'b0, mk_pl(64'hD, 2'b01, 5'd6));
    check("bp_hold_a", PW'(rd_data_out), PW'(64'hA));
    cycle(1'b0, 1'b1, 1'b0, rand_pl());
    cycle(1'b0, 1'b1, 1'b0, rand_pl());
    cycle(1'b0, 1'b1, 1'b0, rand_pl());

    // flush while full with an incoming entry that must vanish
    cycle(1'b1, 1'b0, 1'b0, mk_pl(64'hA, 2'b01, 5'd3));
    cycle(1'b1, 1'b0, 1'b0, mk_pl(64'hB, 2'b01, 5'd4));
    cycle(1'b1, 1'b0, 1'b1, mk_pl(64'hC, 2'b01, 5'd5));
    cycle(1'b0, 1'b1, 1'b0, rand_pl());
`ifdef MEM_WB_PERF_EN
    check("flush_cnt_one", PW'(flush_cnt), PW'(1));
`endif
    cycle(1'b0, 1'b1, 1'b0, rand_pl());

    // wb_we qualification
    cycle(1'b1, 1'b1, 1'b0, mk_pl(64'h11, 2'b01, 5'd0));
    cycle(1'b1, 1'b1, 1'b0, mk_pl(64'h22, 2'b01, 5'd5));
    cycle(1'b1, 1'b1, 1'b0, mk_pl(64'h33, 2'b10, 5'd5));
    cycle(1'b0, 1'b1, 1'b0, rand_pl());
    // emit during a flush cycle still writes back
    cycle(1'b1, 1'b1, 1'b0, mk_pl(64'h44, 2'b01, 5'd7));
    cycle(1'b0, 1'b1, 1'b1, rand_pl());
    cycle(1'b0, 1'b1, 1'b0, rand_pl());

    // reset in the middle of traffic
    cycle(1'b1, 1'b0, 1'b0, rand_pl());
    cycle(1'b1, 1'b0, 1'b0, rand_pl());
    apply_reset();

    // random valid/ready/flush traffic
    for (int i = 0; i < 1000; i++) begin
      p = rand_pl();
      cycle(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 2), p);
    end
    cycle(1'b0, 1'b1, 1'b0, rand_pl());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
